fb_addr_gen: RTL and testbench
==============================

// Module: fb_addr_gen
// PURPOSE
//  Sequential framebuffer address generator for the pong video path.
//  Scan port: walks the FB_W x FB_H framebuffer in raster order, one step per display-pixel strobe.
//  Scan port: replicates each framebuffer pixel SCALE_X times horizontally and each line SCALE_Y times vertically.
//  Scan port: produces read addresses with no multiplier, using an incremental row-base register.
//  Random-access port: translates game-logic (x,y) write coordinates to linear addresses through a 2-stage pipeline.
//  Random-access port: out-of-range coordinates are flagged.
// PARAMETERS
//  FB_W    200  framebuffer width, pixels
//  FB_H    150  framebuffer height, lines
//  SCALE_X 4    horizontal replication factor, >=1
//  SCALE_Y 4    vertical replication factor, >=1
//  COORD_W 9    width of x/y coordinates
//  ADDR_W  16   address width; 2**ADDR_W >= FB_W*FB_H
// PORTS
//  clk         in   1        single clock; all logic on rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  frame_start in   1        1-cycle pulse: restart scan at (0,0)
//  pix_en      in   1        display-pixel strobe: advance scan one step
//  scan_addr   out  ADDR_W   framebuffer read address
//  scan_valid  out  1        scan_addr valid this cycle
//  scan_x      out  COORD_W  fb x of scan_addr
//  scan_y      out  COORD_W  fb y of scan_addr
//  line_end    out  1        with scan_valid: last pixel of a display line
//  frame_end   out  1        with scan_valid: last pixel of the frame
//  overrun     out  1        sticky: pix_en arrived after frame_end
//  req_valid   in   1        random-access request
//  req_x       in   COORD_W  request x
//  req_y       in   COORD_W  request y
//  resp_valid  out  1        response valid, 2 cycles after req_valid
//  resp_addr   out  ADDR_W   req_y*FB_W+req_x; 0 when resp_err
//  resp_err    out  1        request had req_x>=FB_W or req_y>=FB_H
// BEHAVIOUR
//  Reset values:
//   - All outputs 0.
//   - Counters 0: sub_x, fb_x, sub_y, fb_y.
//   - row_base 0; done flag clear.
//  Scan port:
//   - Latency 1: pix_en in cycle N -> scan_valid=1 in N+1.
//   - scan_addr = row_base + fb_x, registered; no multiply in scan path.
//  Scan advance, per pix_en:
//   - sub_x++.
//   - At sub_x==SCALE_X-1: sub_x=0, fb_x++.
//   - At fb_x==FB_W-1: fb_x=0; line_end=1 on that output; sub_y++.
//   - At sub_y==SCALE_Y-1: sub_y=0, fb_y++, row_base+=FB_W. Otherwise row_base is unchanged, so the line repeats.
//   - At fb_y==FB_H-1 with line wrap: frame_end=1; done set; counters hold at 0.
//  After done:
//   - pix_en is ignored; scan_valid stays 0.
//   - overrun set, held until frame_start or reset.
//  frame_start (any time, incl. mid-frame):
//   - Clears counters, row_base, done and overrun.
//   - Same cycle as pix_en: clear first, then the step emits addr 0.
//  Random-access port, stage 1:
//   - Registers prod=req_y*FB_W (constant multiply), req_x, and the range check.
//  Random-access port, stage 2:
//   - resp_addr=prod+req_x, resp_err, resp_valid.
//  Random-access port, general:
//   - Fully pipelined; accepts one request per cycle with no stall.
//   - Independent of the scan port; both may be active in the same cycle.
//  Width rules:
//   - Arithmetic is done at ADDR_W.
//   - Coordinates are zero-extended.
//   - Maximum address FB_W*FB_H-1 (29999 at defaults) never wraps.
//  Reset asserted mid-operation: all state and the pipeline clear immediately; in-flight responses are dropped.
// STRUCTURE
//  Shared package pong_video_pkg:
//   - FB_W, FB_H.
//   - Default SCALE_X/SCALE_Y.
//   - ADDR_W, COORD_W.
//   - Function fb_linear(x,y).
//  Sub-module fb_xy2lin: 2-stage random-access pipeline, instantiated once.
//  Scan counters stay in the top module.
// TESTING
//  1. req (20,10) -> 2 cycles later resp_addr=2020, resp_err=0.
//  2. reqs (199,149),(0,1),(1,0) on 3 consecutive cycles -> 29999, 200, 1 on 3 consecutive cycles.
//  3. req (200,0) and req (0,150) -> resp_err=1, resp_addr=0.
//  4. SCALE_X=SCALE_Y=2, continuous pix_en from frame_start.
//     -> Addresses 0,0,1,1,...,199,199, line_end; the same line repeats; then 200,200,...
//     -> frame_end after 4*30000 strobes.
//  5. pix_en after frame_end -> scan_valid=0, overrun=1; frame_start -> overrun=0, next addr 0.
//  6. frame_start mid-line at addr 305 -> next valid addr 0; rst_n low mid-pipeline -> all outputs 0 and no stale resp_valid.

Source files
------------

// File: rtl/pong_video_pkg.sv
// Shared constants and helpers for the pong video path: framebuffer geometry,
// default pixel replication factors, coordinate/address widths.
package pong_video_pkg;

  localparam int FB_W        = 200;
  localparam int FB_H        = 150;
  localparam int SCALE_X_DEF = 4;
  localparam int SCALE_Y_DEF = 4;
  localparam int COORD_W     = 9;
  localparam int ADDR_W      = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [COORD_W-1:0] coord_t;

  // Linear framebuffer address of (x,y) at the default geometry.
  function automatic addr_t fb_linear(input coord_t x, input coord_t y);
    return addr_t'(y) * addr_t'(FB_W) + addr_t'(x);
  endfunction

endpackage

// File: rtl/fb_xy2lin.sv
// Two-stage (x,y) -> linear address pipeline for game-logic writes.
// Stage 1 forms y*FB_W with a constant multiply and the range check,
// stage 2 adds x and forces the address to 0 on an out-of-range request.
module fb_xy2lin #(
  parameter int FB_W    = pong_video_pkg::FB_W,
  parameter int FB_H    = pong_video_pkg::FB_H,
  parameter int COORD_W = pong_video_pkg::COORD_W,
  parameter int ADDR_W  = pong_video_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  output logic               resp_valid,
  output logic [ADDR_W-1:0]  resp_addr,
  output logic               resp_err
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(FB_W);
  localparam logic [CW1-1:0]    X_LIM = CW1'(FB_W);
  localparam logic [CW1-1:0]    Y_LIM = CW1'(FB_H);

  logic               vld_p1_q,  vld_p1_d;
  logic [ADDR_W-1:0]  prod_p1_q, prod_p1_d;
  logic [COORD_W-1:0] x_p1_q,    x_p1_d;
  logic               err_p1_q,  err_p1_d;

  logic               vld_p2_q,  vld_p2_d;
  logic [ADDR_W-1:0]  addr_p2_q, addr_p2_d;
  logic               err_p2_q,  err_p2_d;

  // Stage 1: row product, captured x, range check
  always_comb begin
    vld_p1_d  = req_valid;
    prod_p1_d = ADDR_W'(req_y) * W_A;
    x_p1_d    = req_x;
    err_p1_d  = ({1'b0, req_x} >= X_LIM) || ({1'b0, req_y} >= Y_LIM);
  end

  // Stage 2: final address, zeroed for rejected requests
  always_comb begin
    vld_p2_d  = vld_p1_q;
    err_p2_d  = vld_p1_q & err_p1_q;
    addr_p2_d = '0;
    if (vld_p1_q && !err_p1_q) begin
      addr_p2_d = prod_p1_q + ADDR_W'(x_p1_q);
    end
  end

  // Pipeline registers; reset drops anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      prod_p1_q <= '0;
      x_p1_q    <= '0;
      err_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      addr_p2_q <= '0;
      err_p2_q  <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      prod_p1_q <= prod_p1_d;
      x_p1_q    <= x_p1_d;
      err_p1_q  <= err_p1_d;
      vld_p2_q  <= vld_p2_d;
      addr_p2_q <= addr_p2_d;
      err_p2_q  <= err_p2_d;
    end
  end

  assign resp_valid = vld_p2_q;
  assign resp_addr  = addr_p2_q;
  assign resp_err   = err_p2_q;

endmodule

// File: rtl/fb_addr_gen.sv
// Framebuffer address generator: raster scan with pixel/line replication
// driven by a display-pixel strobe, plus an independent random-access
// (x,y) -> address translation port for game-logic writes.
module fb_addr_gen
  import pong_video_pkg::*;
#(
  parameter int FB_W    = pong_video_pkg::FB_W,
  parameter int FB_H    = pong_video_pkg::FB_H,
  parameter int SCALE_X = SCALE_X_DEF,
  parameter int SCALE_Y = SCALE_Y_DEF,
  parameter int COORD_W = pong_video_pkg::COORD_W,
  parameter int ADDR_W  = pong_video_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               pix_en,
  output logic [ADDR_W-1:0]  scan_addr,
  output logic               scan_valid,
  output logic [COORD_W-1:0] scan_x,
  output logic [COORD_W-1:0] scan_y,
  output logic               line_end,
  output logic               frame_end,
  output logic               overrun,
  input  logic               req_valid,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  output logic               resp_valid,
  output logic [ADDR_W-1:0]  resp_addr,
  output logic               resp_err
);

  localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
  localparam logic [SXW-1:0]     SX_LAST = SXW'(SCALE_X - 1);
  localparam logic [SYW-1:0]     SY_LAST = SYW'(SCALE_Y - 1);
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(FB_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(FB_H - 1);
  localparam logic [ADDR_W-1:0]  W_A     = ADDR_W'(FB_W);

  // Scan position state
  logic [SXW-1:0]     sub_x_q,    sub_x_d,    sub_x_c;
  logic [COORD_W-1:0] fb_x_q,     fb_x_d,     fb_x_c;
  logic [SYW-1:0]     sub_y_q,    sub_y_d,    sub_y_c;
  logic [COORD_W-1:0] fb_y_q,     fb_y_d,     fb_y_c;
  logic [ADDR_W-1:0]  row_base_q, row_base_d, row_base_c;
  logic               done_q,     done_d;
  logic               overrun_q,  overrun_d;

  // Registered scan outputs
  logic [ADDR_W-1:0]  scan_addr_q,  scan_addr_d;
  logic               scan_valid_q, scan_valid_d;
  logic [COORD_W-1:0] scan_x_q,     scan_x_d;
  logic [COORD_W-1:0] scan_y_q,     scan_y_d;
  logic               line_end_q,   line_end_d;
  logic               frame_end_q,  frame_end_d;

  // Next-state for the scan: apply frame_start first, then take one step on pix_en
  always_comb begin
    sub_x_c    = frame_start ? '0 : sub_x_q;
    fb_x_c     = frame_start ? '0 : fb_x_q;
    sub_y_c    = frame_start ? '0 : sub_y_q;
    fb_y_c     = frame_start ? '0 : fb_y_q;
    row_base_c = frame_start ? '0 : row_base_q;

    sub_x_d    = sub_x_c;
    fb_x_d     = fb_x_c;
    sub_y_d    = sub_y_c;
    fb_y_d     = fb_y_c;
    row_base_d = row_base_c;
    done_d     = frame_start ? 1'b0 : done_q;
    overrun_d  = frame_start ? 1'b0 : overrun_q;

    scan_valid_d = 1'b0;
    line_end_d   = 1'b0;
    frame_end_d  = 1'b0;
    scan_addr_d  = scan_addr_q;
    scan_x_d     = scan_x_q;
    scan_y_d     = scan_y_q;

    if (pix_en) begin
      if (done_d) begin
        overrun_d = 1'b1;
      end else begin
        scan_valid_d = 1'b1;
        scan_addr_d  = row_base_c + ADDR_W'(fb_x_c);
        scan_x_d     = fb_x_c;
        scan_y_d     = fb_y_c;
        if (sub_x_c != SX_LAST) begin
          sub_x_d = sub_x_c + SXW'(1);
        end else begin
          sub_x_d = '0;
          if (fb_x_c != X_LAST) begin
            fb_x_d = fb_x_c + COORD_W'(1);
          end else begin
            fb_x_d     = '0;
            line_end_d = 1'b1;
            if (sub_y_c != SY_LAST) begin
              // Same framebuffer line is replayed: row_base untouched
              sub_y_d = sub_y_c + SYW'(1);
            end else begin
              sub_y_d = '0;
              if (fb_y_c != Y_LAST) begin
                fb_y_d     = fb_y_c + COORD_W'(1);
                row_base_d = row_base_c + W_A;
              end else begin
                fb_y_d      = '0;
                row_base_d  = '0;
                done_d      = 1'b1;
                frame_end_d = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Scan state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_x_q      <= '0;
      fb_x_q       <= '0;
      sub_y_q      <= '0;
      fb_y_q       <= '0;
      row_base_q   <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      scan_addr_q  <= '0;
      scan_valid_q <= 1'b0;
      scan_x_q     <= '0;
      scan_y_q     <= '0;
      line_end_q   <= 1'b0;
      frame_end_q  <= 1'b0;
    end else begin
      sub_x_q      <= sub_x_d;
      fb_x_q       <= fb_x_d;
      sub_y_q      <= sub_y_d;
      fb_y_q       <= fb_y_d;
      row_base_q   <= row_base_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      scan_addr_q  <= scan_addr_d;
      scan_valid_q <= scan_valid_d;
      scan_x_q     <= scan_x_d;
      scan_y_q     <= scan_y_d;
      line_end_q   <= line_end_d;
      frame_end_q  <= frame_end_d;
    end
  end

  assign scan_addr  = scan_addr_q;
  assign scan_valid = scan_valid_q;
  assign scan_x     = scan_x_q;
  assign scan_y     = scan_y_q;
  assign line_end   = line_end_q;
  assign frame_end  = frame_end_q;
  assign overrun    = overrun_q;

  fb_xy2lin #(
    .FB_W    (FB_W),
    .FB_H    (FB_H),
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W)
  ) u_xy2lin (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_addr  (resp_addr),
    .resp_err   (resp_err)
  );

endmodule

// File: tb/tb_fb_addr_gen.sv
// Scoreboard bench for fb_addr_gen: a full-size instance (200x150, 2x2
// replication) for the random-access port and the start of a scan, and a
// tiny 8x4 instance to reach frame_end and overrun quickly.
module tb_fb_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic rst_n;

  // Full-size instance
  logic        frame_start_m, pix_en_m, req_valid_m;
  logic [8:0]  req_x_m, req_y_m;
  logic [15:0] scan_addr_m, resp_addr_m;
  logic [8:0]  scan_x_m, scan_y_m;
  logic        scan_valid_m, line_end_m, frame_end_m, overrun_m;
  logic        resp_valid_m, resp_err_m;

  // Small instance
  logic        frame_start_s, pix_en_s, req_valid_s;
  logic [8:0]  req_x_s, req_y_s;
  logic [15:0] scan_addr_s, resp_addr_s;
  logic [8:0]  scan_x_s, scan_y_s;
  logic        scan_valid_s, line_end_s, frame_end_s, overrun_s;
  logic        resp_valid_s, resp_err_s;

  fb_addr_gen #(.SCALE_X(2), .SCALE_Y(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start_m), .pix_en(pix_en_m),
    .scan_addr(scan_addr_m), .scan_valid(scan_valid_m), .scan_x(scan_x_m),
    .scan_y(scan_y_m), .line_end(line_end_m), .frame_end(frame_end_m),
    .overrun(overrun_m), .req_valid(req_valid_m), .req_x(req_x_m),
    .req_y(req_y_m), .resp_valid(resp_valid_m), .resp_addr(resp_addr_m),
    .resp_err(resp_err_m)
  );

  fb_addr_gen #(.FB_W(8), .FB_H(4), .SCALE_X(2), .SCALE_Y(2)) u_sml (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start_s), .pix_en(pix_en_s),
    .scan_addr(scan_addr_s), .scan_valid(scan_valid_s), .scan_x(scan_x_s),
    .scan_y(scan_y_s), .line_end(line_end_s), .frame_end(frame_end_s),
    .overrun(overrun_s), .req_valid(req_valid_s), .req_x(req_x_s),
    .req_y(req_y_s), .resp_valid(resp_valid_s), .resp_addr(resp_addr_s),
    .resp_err(resp_err_s)
  );

  typedef struct {
    logic [15:0] addr;
    logic        err;
    int          due;
  } resp_t;

  typedef struct {
    logic [15:0] addr;
    logic        le;
    logic        fe;
    int          due;
  } scan_t;

  resp_t resp_q[$];
  scan_t scan_q[$];
  scan_t scans_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input int x, input int y, input int addr, input logic err);
    resp_t r;
    req_valid_m = 1'b1;
    req_x_m     = 9'(x);
    req_y_m     = 9'(y);
    r.addr = 16'(addr);
    r.err  = err;
    r.due  = cyc + 2;
    resp_q.push_back(r);
  endtask

  // Monitor: pop expected entries whenever a DUT output is valid
  resp_t mr;
  scan_t ms;
  always @(negedge clk) begin
    if (resp_valid_m) begin
      if (resp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected: got resp_valid=1 addr=%0d expected no response", resp_addr_m);
      end else begin
        mr = resp_q.pop_front();
        chk("resp_addr", 32'(resp_addr_m), 32'(mr.addr));
        chk("resp_err", 32'(resp_err_m), 32'(mr.err));
        chk("resp_latency", 32'(cyc), 32'(mr.due));
      end
    end
    if (scan_valid_m) begin
      if (scan_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scan_unexpected: got scan_valid=1 addr=%0d expected idle", scan_addr_m);
      end else begin
        ms = scan_q.pop_front();
        chk("scan_addr", 32'(scan_addr_m), 32'(ms.addr));
        chk("scan_line_end", 32'(line_end_m), 32'(ms.le));
        chk("scan_frame_end", 32'(frame_end_m), 32'(ms.fe));
        chk("scan_latency", 32'(cyc), 32'(ms.due));
      end
    end
    if (scan_valid_s) begin
      if (scans_q.size() == 0) begin
        total++; bad++;
        $display("FAIL small_scan_unexpected: got scan_valid=1 addr=%0d expected idle", scan_addr_s);
      end else begin
        ms = scans_q.pop_front();
        chk("small_scan_addr", 32'(scan_addr_s), 32'(ms.addr));
        chk("small_line_end", 32'(line_end_s), 32'(ms.le));
        chk("small_frame_end", 32'(frame_end_s), 32'(ms.fe));
        chk("small_scan_latency", 32'(cyc), 32'(ms.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    scan_t s;
    rst_n = 1'b0;
    frame_start_m = 1'b0; pix_en_m = 1'b0; req_valid_m = 1'b0; req_x_m = '0; req_y_m = '0;
    frame_start_s = 1'b0; pix_en_s = 1'b0; req_valid_s = 1'b0; req_x_s = '0; req_y_s = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_scan_valid", 32'(scan_valid_m), 0);
    chk("rst_scan_addr", 32'(scan_addr_m), 0);
    chk("rst_line_end", 32'(line_end_m), 0);
    chk("rst_frame_end", 32'(frame_end_m), 0);
    chk("rst_overrun", 32'(overrun_m), 0);
    chk("rst_resp_valid", 32'(resp_valid_m), 0);
    chk("rst_resp_addr", 32'(resp_addr_m), 0);
    chk("rst_small_overrun", 32'(overrun_s), 0);
    rst_n = 1'b1;
    tick();

    // Single request
    send_req(20, 10, 2020, 1'b0);
    tick();
    req_valid_m = 1'b0;
    repeat (3) tick();

    // Back-to-back requests, corner of the framebuffer
    send_req(199, 149, 29999, 1'b0); tick();
    send_req(0, 1, 200, 1'b0);       tick();
    send_req(1, 0, 1, 1'b0);         tick();
    // Out-of-range requests
    send_req(200, 0, 0, 1'b1);       tick();
    send_req(0, 150, 0, 1'b1);       tick();
    send_req(511, 511, 0, 1'b1);     tick();
    req_valid_m = 1'b0;
    repeat (4) tick();

    // Scan from frame_start with 2x2 replication, up to address 305 on row 1;
    // a random-access request overlaps the scan
    for (int i = 0; i < 1012; i++) begin
      frame_start_m = (i == 0);
      pix_en_m = 1'b1;
      s.addr = 16'((i / 800) * 200 + (i / 2) % 200);
      s.le   = ((i % 400) == 399);
      s.fe   = 1'b0;
      s.due  = cyc + 1;
      scan_q.push_back(s);
      if (i == 10) send_req(5, 2, 405, 1'b0);
      else req_valid_m = 1'b0;
      tick();
    end
    frame_start_m = 1'b0;
    pix_en_m = 1'b0;
    req_valid_m = 1'b0;

    // frame_start mid-line restarts at address 0
    frame_start_m = 1'b1;
    tick();
    frame_start_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pix_en_m = 1'b1;
      s.addr = 16'(i / 2); s.le = 1'b0; s.fe = 1'b0; s.due = cyc + 1;
      scan_q.push_back(s);
      tick();
    end
    pix_en_m = 1'b0;
    repeat (2) tick();

    // Whole frame on the small instance: 8x4 at 2x2 is 128 strobes
    for (int i = 0; i < 128; i++) begin
      frame_start_s = (i == 0);
      pix_en_s = 1'b1;
      s.addr = 16'((i / 32) * 8 + (i / 2) % 8);
      s.le   = ((i % 16) == 15);
      s.fe   = (i == 127);
      s.due  = cyc + 1;
      scans_q.push_back(s);
      tick();
    end
    frame_start_s = 1'b0;
    // Strobes after frame_end are ignored and set overrun
    repeat (2) tick();
    pix_en_s = 1'b0;
    tick();
    chk("overrun_set", 32'(overrun_s), 1);
    chk("done_no_valid", 32'(scan_valid_s), 0);
    tick();
    chk("overrun_sticky", 32'(overrun_s), 1);
    frame_start_s = 1'b1;
    tick();
    frame_start_s = 1'b0;
    chk("overrun_cleared", 32'(overrun_s), 0);
    for (int i = 0; i < 2; i++) begin
      pix_en_s = 1'b1;
      s.addr = 16'd0; s.le = 1'b0; s.fe = 1'b0; s.due = cyc + 1;
      scans_q.push_back(s);
      tick();
    end
    pix_en_s = 1'b0;
    repeat (2) tick();

    // Reset with a request in flight: the response must be dropped
    send_req(3, 3, 603, 1'b0);
    tick();
    req_valid_m = 1'b0;
    rst_n = 1'b0;
    #1;
    resp_q.delete();
    chk("midrst_resp_valid", 32'(resp_valid_m), 0);
    chk("midrst_resp_addr", 32'(resp_addr_m), 0);
    chk("midrst_scan_addr", 32'(scan_addr_m), 0);
    chk("midrst_scan_valid", 32'(scan_valid_m), 0);
    chk("midrst_small_scan_addr", 32'(scan_addr_s), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("postrst_resp_valid", 32'(resp_valid_m), 0);

    // Every expected response must have been seen
    chk("resp_queue_drained", 32'(resp_q.size()), 0);
    chk("scan_queue_drained", 32'(scan_q.size()), 0);
    chk("small_queue_drained", 32'(scans_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
